// File: rtl/data_mem_responder_pkg.sv
// Shared RV32I load/store encodings, FSM state type and access helpers
// for the data-memory responder.
package data_mem_responder_pkg;

  // funct3 encodings for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 encodings for stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Major opcodes the control unit decodes into dMemRead / dMemWrite
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the access cannot be performed: bad size code for the
  // direction, or a half/word that is not naturally aligned.
  function automatic logic access_err(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic err;
    err = 1'b1;
    if (is_store) begin
      case (f3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = off[0];
        F3_SW:   err = (off != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = off[0];
        F3_LW:         err = (off != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_SB:   be = 4'b0001 << off;
      F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the byte enables pick the slot.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_SB:   d = {4{wd[7:0]}};
      F3_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Select the addressed byte/half of a word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word store with a byte-enable write port and a registered
// read port. Storage is never reset; only the read register is, so the
// responder's load result starts at zero.
module data_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Byte-lane write into the storage array
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read register; only updated by an enabled read so it holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the multi-cycle RV32I core. Accepts one load or
// store per request, checks size/alignment, waits LATENCY cycles and
// pulses memReady (with memErr on illegal requests).
//
// Handshake: a request is a level on dMemRead or dMemWrite sampled in
// IDLE. The responder answers with memReady high for exactly one cycle
// LATENCY cycles after acceptance; the master must drop its strobe in
// that cycle or a new access starts in the following IDLE cycle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dMemRead,
  input  logic        dMemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        memErr,
  output state_t      dbgState
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;

  // Captured request
  logic           r_is_store;
  logic           r_err;
  logic [2:0]     r_f3;
  logic [AW+1:0]  r_addr;
  logic [31:0]    r_wdata;

  // Size/offset of the load whose word is in the array read register
  logic [2:0]     r_ld_f3;
  logic [1:0]     r_ld_off;

  logic           w_req;
  logic           w_req_err;
  logic           w_accept;
  logic           w_to_resp;
  logic           w_rd_en;
  logic [AW-1:0]  w_rd_idx;
  logic [2:0]     w_rd_f3;
  logic [1:0]     w_rd_off;
  logic           w_we;
  logic [31:0]    w_rd_q;
  logic           w_unused;

  // Upper address bits are deliberately dropped: addresses wrap modulo DEPTH*4
  assign w_unused = ^addr[31:AW+2];

  assign w_req     = dMemRead | dMemWrite;
  assign w_req_err = (dMemRead & dMemWrite) | access_err(dMemWrite, funct3, addr[1:0]);

  // State register and latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: IDLE accepts, WAIT burns cycles, RESP answers
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_to_resp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next    = ST_RESP;
            w_to_resp = 1'b1;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = CW'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next    = ST_RESP;
          w_to_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_err      <= 1'b0;
      r_f3       <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_is_store <= dMemWrite;
      r_err      <= w_req_err;
      r_f3       <= funct3;
      r_addr     <= addr[AW+1:0];
      r_wdata    <= writeData;
    end
  end

  // Read is launched on the edge entering RESP. With LATENCY 1 that edge
  // is the acceptance edge, so the live request is used; otherwise the
  // captured one.
  always_comb begin
    w_rd_en  = 1'b0;
    w_rd_idx = r_addr[AW+1:2];
    w_rd_f3  = r_f3;
    w_rd_off = r_addr[1:0];
    if (r_state == ST_IDLE) begin
      w_rd_en  = w_to_resp & dMemRead & ~w_req_err;
      w_rd_idx = addr[AW+1:2];
      w_rd_f3  = funct3;
      w_rd_off = addr[1:0];
    end else begin
      w_rd_en  = w_to_resp & ~r_is_store & ~r_err;
    end
  end

  // Remember how to extend the word sitting in the read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_f3  <= 3'd0;
      r_ld_off <= 2'd0;
    end else if (w_rd_en) begin
      r_ld_f3  <= w_rd_f3;
      r_ld_off <= w_rd_off;
    end
  end

  // Store commits on the edge that ends RESP; a reset before then drops it
  assign w_we = (r_state == ST_RESP) & r_is_store & ~r_err;

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_be    (store_be(r_f3, r_addr[1:0])),
    .i_waddr (r_addr[AW+1:2]),
    .i_wdata (store_data(r_f3, r_wdata)),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_q)
  );

  assign readData = load_extend(r_ld_f3, r_ld_off, w_rd_q);
  assign memReady = (r_state == ST_RESP);
  assign memErr   = (r_state == ST_RESP) & r_err;
  assign dbgState = r_state;

endmodule
